// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - scan-code read port and error flags of the PS/2 keyboard receiver
// Signals:
//   rd_en     pop request from the consumer (master -> slave)
//   clr_err   one-cycle pulse clearing the sticky flags (master -> slave)
//   dout      scan code at FIFO head, show-ahead (slave -> master)
//   valid     FIFO not empty (slave -> master)
//   overflow  sticky: good frame dropped, FIFO full (slave -> master)
//   frame_err sticky: start/stop/parity error or timeout (slave -> master)
interface ps2_kbd_rx_if;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] dout;
   logic       valid;
   logic       overflow;
   logic       frame_err;

   modport master (
      output rd_en, clr_err,
      input  dout, valid, overflow, frame_err
   );

   modport slave (
      input  rd_en, clr_err,
      output dout, valid, overflow, frame_err
   );
endinterface

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame deserializer with show-ahead scan-code FIFO
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   ps2_clk   raw PS/2 clock pad, asynchronous
//   ps2_data  raw PS/2 data pad, asynchronous
//   bus       ps2_kbd_rx_if.slave: rd_en/clr_err in, dout/valid/overflow/frame_err out
module ps2_kbd_rx #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 20000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   ps2_kbd_rx_if.slave    bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [IW-1:0] TO_LIM   = IW'(TIMEOUT);

   // ---------------- synchronizer ----------------
   logic pc1_q, pc2_q, pc3_q;
   logic pd1_q, pd2_q;
   logic fall;
   logic bit_in;

   // Idle bus level is high, so resetting to 1 avoids a false edge on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc1_q <= 1'b1;
         pc2_q <= 1'b1;
         pc3_q <= 1'b1;
         pd1_q <= 1'b1;
         pd2_q <= 1'b1;
      end else begin
         pc1_q <= ps2_clk;
         pc2_q <= pc1_q;
         pc3_q <= pc2_q;
         pd1_q <= ps2_data;
         pd2_q <= pd1_q;
      end
   end

   assign fall   = pc3_q & ~pc2_q;
   assign bit_in = pd2_q;

   // ---------------- deserializer + timeout ----------------
   logic [3:0]    cnt_q,   cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [IW-1:0] idle_q,  idle_d;
   logic          frame_good;
   logic          frame_bad;

   // Bits enter at the MSB, so after ten shifts shift_q[0] is the start bit,
   // shift_q[8:1] is d0..d7 and shift_q[9] is parity.
   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      idle_d     = idle_q;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      if (fall) begin
         idle_d = '0;
         if (cnt_q != 4'd10) begin
            shift_d = {bit_in, shift_q[9:1]};
            cnt_d   = cnt_q + 4'd1;
         end else begin
            cnt_d = 4'd0;
            if (!shift_q[0] && bit_in && (^shift_q[9:1]))
               frame_good = 1'b1;
            else
               frame_bad = 1'b1;
         end
      end else if (cnt_q != 4'd0) begin
         if (idle_q == TO_LIM) begin
            cnt_d     = 4'd0;
            idle_d    = '0;
            frame_bad = 1'b1;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end else begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 4'd0;
         shift_q <= '0;
         idle_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         idle_q  <= idle_d;
      end
   end

   // ---------------- FIFO ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overflow_q,  overflow_d;
   logic          frame_err_q, frame_err_d;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          ovf_set;

   assign pop     = bus.rd_en && (count_q != '0);
   assign full    = (count_q == FULL_CNT);
   // A simultaneous pop frees the slot, so a full FIFO can still accept.
   assign push_ok = frame_good && (!full || pop);
   assign ovf_set = frame_good && full && !pop;

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Set events take priority over the clear pulse.
      overflow_d  = ovf_set   ? 1'b1 : (bus.clr_err ? 1'b0 : overflow_q);
      frame_err_d = frame_bad ? 1'b1 : (bus.clr_err ? 1'b0 : frame_err_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_q] <= shift_q[8:1];
   end

   assign bus.dout      = mem[rd_ptr_q];
   assign bus.valid     = (count_q != '0);
   assign bus.overflow  = overflow_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed scoreboard bench for ps2_kbd_rx
module tb_ps2_kbd_rx;

   localparam int DEPTH = 8;
   localparam int TO    = 200;
   localparam int HALF  = 20;

   logic clk = 1'b0;
   logic rst;
   logic ps2_clk;
   logic ps2_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sb [$];
   logic       ov_exp;

   ps2_kbd_rx_if bus ();

   ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic badpar);
      logic [10:0] f;
      f[0]   = 1'b0;
      f[8:1] = d;
      f[9]   = ~(^d) ^ badpar;
      f[10]  = 1'b1;
      return f;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits);
      logic [10:0] f;
      f = frame_bits(d, 1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
   endtask

   // Sends a full frame; locates the stop-bit fall, optionally pops on the
   // push cycle, and reports valid on the cycle right after the fall.
   task automatic send_frame(input logic [7:0] d, input logic badpar,
                             input logic pop_at_push, output logic valid_next);
      logic [10:0] f;
      logic        found;
      logic [7:0]  head;
      f = frame_bits(d, badpar);
      for (int i = 0; i < 10; i++) ps2_bit(f[i]);
      ps2_data = f[10];
      cycles(HALF);
      ps2_clk = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (dut.fall) begin
            found = 1'b1;
            break;
         end
      end
      chk("stop_fall_seen", {31'd0, found}, 32'd1);
      if (pop_at_push) begin
         head = bus.dout;
         if (sb.size() > 0) chk("pop_at_push_head", {24'd0, head}, {24'd0, sb.pop_front()});
         bus.rd_en = 1'b1;
      end
      @(negedge clk);
      bus.rd_en = 1'b0;
      valid_next = bus.valid;
      if (!badpar) begin
         if (sb.size() < DEPTH) sb.push_back(d);
         else ov_exp = 1'b1;
      end
      cycles(HALF);
      ps2_clk = 1'b1;
      cycles(HALF);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_dout"}, {24'd0, bus.dout}, {24'd0, e});
      end else begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      ov_exp = 1'b0;
   endtask

   initial begin
      logic vn;
      rst         = 1'b1;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;
      bus.rd_en   = 1'b0;
      bus.clr_err = 1'b0;
      ov_exp      = 1'b0;
      cycles(3);
      rst = 1'b0;
      cycles(2);

      // reset state
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);

      // single frame 0x1C, valid one cycle after stop-bit fall
      send_frame(8'h1C, 1'b0, 1'b0, vn);
      chk("t1_valid_next", {31'd0, vn}, 32'd1);
      pop_check("t1_pop");
      chk("t1_empty", {31'd0, bus.valid}, 32'd0);

      // back to back F0, 1C
      send_frame(8'hF0, 1'b0, 1'b0, vn);
      send_frame(8'h1C, 1'b0, 1'b0, vn);
      chk("t2_count", 32'(dut.count_q), 32'd2);
      chk("t2_ferr", {31'd0, bus.frame_err}, 32'd0);
      chk("t2_ovf", {31'd0, bus.overflow}, 32'd0);
      pop_check("t2_pop0");
      pop_check("t2_pop1");
      chk("t2_empty", {31'd0, bus.valid}, 32'd0);
      chk("t2_ferr_end", {31'd0, bus.frame_err}, 32'd0);

      // bad parity
      send_frame(8'h1C, 1'b1, 1'b0, vn);
      chk("t3_valid", {31'd0, bus.valid}, 32'd0);
      chk("t3_ferr", {31'd0, bus.frame_err}, 32'd1);
      pulse_clr();
      chk("t3_ferr_clr", {31'd0, bus.frame_err}, 32'd0);

      // overflow: nine frames, no reads
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, vn);
      chk("t4_ovf", {31'd0, bus.overflow}, {31'd0, ov_exp});
      chk("t4_count", 32'(dut.count_q), 32'd8);
      for (int i = 0; i < 8; i++) pop_check("t4_pop");
      chk("t4_empty", {31'd0, bus.valid}, 32'd0);
      pulse_clr();
      chk("t4_ovf_clr", {31'd0, bus.overflow}, 32'd0);

      // full FIFO, pop on the push cycle of the ninth frame
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, vn);
      send_frame(8'h09, 1'b0, 1'b1, vn);
      chk("t5_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("t5_count", 32'(dut.count_q), 32'd8);
      for (int i = 0; i < 8; i++) pop_check("t5_pop");
      chk("t5_empty", {31'd0, bus.valid}, 32'd0);

      // timeout after 5 bits
      send_partial(8'hA5, 5);
      cycles(TO + 20);
      chk("t6_ferr", {31'd0, bus.frame_err}, 32'd1);
      chk("t6_cnt", 32'(dut.cnt_q), 32'd0);
      pulse_clr();
      send_frame(8'h5A, 1'b0, 1'b0, vn);
      chk("t6_ferr_after", {31'd0, bus.frame_err}, 32'd0);
      pop_check("t6_pop");

      // reset mid-frame with data buffered and an error flag set
      send_frame(8'h11, 1'b0, 1'b0, vn);
      send_frame(8'h22, 1'b1, 1'b0, vn);
      send_partial(8'h33, 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      ov_exp = 1'b0;
      chk("t7_valid", {31'd0, bus.valid}, 32'd0);
      chk("t7_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("t7_ferr", {31'd0, bus.frame_err}, 32'd0);
      chk("t7_cnt", 32'(dut.cnt_q), 32'd0);
      cycles(HALF);
      send_frame(8'h29, 1'b0, 1'b0, vn);
      chk("t7_valid_next", {31'd0, vn}, 32'd1);
      pop_check("t7_pop");
      chk("t7_ferr_end", {31'd0, bus.frame_err}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
